// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with IDLE / RUN / EXPIRED states.
// A run is started by START with a nonzero LOAD_VAL, advanced by TICK and
// ends in EXPIRED, where DONE holds until ACK, START or ABORT.
//
// Handshake note: START, ABORT, TICK and ACK are single-cycle qualifiers
// with no ready/back-pressure; each is acted on in the cycle it is sampled
// high at a rising CLK edge, with priority RST_n, ABORT, START, TICK/ACK.
//
// dbg_state exposes the registered state for checkers:
// 2'd0 = IDLE, 2'd1 = RUN, 2'd2 = EXPIRED.
module countdown_timer #(
    parameter int modulus = 16,
    localparam int N = $clog2(modulus)
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         START,
    input  logic [N-1:0] LOAD_VAL,
    input  logic         TICK,
    input  logic         ABORT,
    input  logic         ACK,
    output logic [N-1:0] COUNT,
    output logic         BUSY,
    output logic         DONE,
    output logic         EXPIRE,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Largest legal count, held one bit wider than COUNT so the saturation
    // compare below is a real compare for every modulus, including powers of 2.
    localparam logic [N:0] MAX_WIDE = (N+1)'(modulus - 1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] count_next;
    logic [N:0]   load_wide;
    logic [N-1:0] load_sat;
    logic         load_zero;
    logic         count_one;

    // Saturate the requested load to modulus-1 and decode the terminal count.
    always_comb begin
        load_wide = {1'b0, LOAD_VAL};
        load_sat  = (load_wide > MAX_WIDE) ? MAX_WIDE[N-1:0] : LOAD_VAL;
        load_zero = (LOAD_VAL == '0);
        count_one = (COUNT == N'(1));
    end

    // State and count registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
            COUNT <= '0;
        end else begin
            state <= state_next;
            COUNT <= count_next;
        end
    end

    // Next-state, next-count and the combinational EXPIRE pulse.
    always_comb begin
        state_next = state;
        count_next = COUNT;
        EXPIRE     = 1'b0;
        if (!RST_n) begin
            // Reset takes effect at the edge; EXPIRE is held low meanwhile.
            state_next = IDLE;
            count_next = '0;
        end else if (ABORT) begin
            state_next = IDLE;
            count_next = '0;
        end else if (START) begin
            // START restarts from any state and swallows a same-cycle TICK/ACK.
            if (load_zero) begin
                state_next = EXPIRED;
                count_next = '0;
                EXPIRE     = 1'b1;
            end else begin
                state_next = RUN;
                count_next = load_sat;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (TICK) begin
                        if (count_one) begin
                            state_next = EXPIRED;
                            count_next = '0;
                            EXPIRE     = 1'b1;
                        end else if (COUNT != '0) begin
                            count_next = COUNT - N'(1);
                        end
                    end
                end
                EXPIRED: begin
                    if (ACK) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    // IDLE ignores TICK and ACK and holds COUNT.
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        BUSY      = (state == RUN);
        DONE      = (state == EXPIRED);
        dbg_state = state;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (modulus 16 and 10) share one
// stimulus stream; a behavioural model per instance predicts COUNT, BUSY,
// DONE and EXPIRE each cycle.
module tb_countdown_timer;

    localparam int NI = 2;
    localparam int W  = 4;

    logic         CLK;
    logic         RST_n;
    logic         START;
    logic [W-1:0] LOAD_VAL;
    logic         TICK;
    logic         ABORT;
    logic         ACK;

    logic [W-1:0] count_o  [NI];
    logic         busy_o   [NI];
    logic         done_o   [NI];
    logic         expire_o [NI];
    logic [1:0]   dbg_o    [NI];

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 running, 2 expired.
    int mods    [NI] = '{16, 10};
    int m_phase [NI];
    int m_count [NI];
    logic [W-1:0] exp_q[$];

    countdown_timer #(.modulus(16)) dut16 (
        .CLK(CLK), .RST_n(RST_n), .START(START), .LOAD_VAL(LOAD_VAL),
        .TICK(TICK), .ABORT(ABORT), .ACK(ACK),
        .COUNT(count_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
        .EXPIRE(expire_o[0]), .dbg_state(dbg_o[0])
    );

    countdown_timer #(.modulus(10)) dut10 (
        .CLK(CLK), .RST_n(RST_n), .START(START), .LOAD_VAL(LOAD_VAL),
        .TICK(TICK), .ABORT(ABORT), .ACK(ACK),
        .COUNT(count_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
        .EXPIRE(expire_o[1]), .dbg_state(dbg_o[1])
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_expire(input int k);
        if (!RST_n || ABORT) return 0;
        if (START) return (LOAD_VAL == 0) ? 1 : 0;
        return (m_phase[k] == 1 && TICK && m_count[k] == 1) ? 1 : 0;
    endfunction

    task automatic model_step(input int k);
        if (!RST_n || ABORT) begin
            m_phase[k] = 0;
            m_count[k] = 0;
        end else if (START) begin
            if (LOAD_VAL == 0) begin
                m_phase[k] = 2;
                m_count[k] = 0;
            end else begin
                m_phase[k] = 1;
                m_count[k] = (int'(LOAD_VAL) > mods[k] - 1) ? mods[k] - 1 : int'(LOAD_VAL);
            end
        end else if (m_phase[k] == 1 && TICK) begin
            m_count[k] = m_count[k] - 1;
            if (m_count[k] == 0) m_phase[k] = 2;
        end else if (m_phase[k] == 2 && ACK) begin
            m_phase[k] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check EXPIRE and held state
    // mid-cycle, step the model at the edge, check registers just after.
    task automatic cycle(input logic s, input int lv, input logic t,
                         input logic ab, input logic ak, input logic r);
        @(negedge CLK);
        START    = s;
        LOAD_VAL = W'(lv);
        TICK     = t;
        ABORT    = ab;
        ACK      = ak;
        RST_n    = r;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("expire[%0d]", k), int'(expire_o[k]), model_expire(k));
            check($sformatf("count_hold[%0d]", k), int'(count_o[k]), m_count[k]);
        end
        @(posedge CLK);
        for (int k = 0; k < NI; k++) begin
            model_step(k);
            exp_q.push_back(W'(m_count[k]));
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("count[%0d]", k), int'(count_o[k]), int'(e));
            check($sformatf("busy[%0d]", k), int'(busy_o[k]), (m_phase[k] == 1) ? 1 : 0);
            check($sformatf("done[%0d]", k), int'(done_o[k]), (m_phase[k] == 2) ? 1 : 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        START = 0; LOAD_VAL = '0; TICK = 0; ABORT = 0; ACK = 0; RST_n = 0;
        for (int k = 0; k < NI; k++) begin
            m_phase[k] = 0;
            m_count[k] = 0;
        end

        // Reset with noisy inputs: reset must win.
        cycle(1, 5, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 1, 0);
        idle_cycles(1);
        check("reset_count", int'(count_o[0]), 0);
        check("reset_busy", int'(busy_o[0]), 0);

        // Basic run: load 3, continuous tick, then ACK.
        cycle(1, 3, 0, 0, 0, 1);
        check("basic_load", int'(count_o[0]), 3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1);
        check("basic_done", int'(done_o[0]), 1);
        cycle(0, 0, 1, 0, 1, 1);
        check("basic_ack", int'(done_o[0]), 0);

        // Sparse tick with load 2.
        cycle(1, 2, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(0, 0, (i % 3) == 2, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1);

        // Zero load, then full-scale load (saturates to 9 on modulus 10).
        cycle(1, 0, 0, 0, 0, 1);
        idle_cycles(1);
        cycle(1, 15, 0, 0, 0, 1);
        check("sat_load10", int'(count_o[1]), 9);
        check("full_load16", int'(count_o[0]), 15);
        for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, 0, 1);
        check("full_expired16", int'(done_o[0]), 1);

        // Collisions.
        cycle(1, 0, 0, 0, 1, 1);   // START+ACK in EXPIRED, zero load
        cycle(1, 6, 1, 0, 1, 1);   // START+ACK in EXPIRED -> RUN
        cycle(0, 0, 1, 0, 0, 1);
        cycle(1, 4, 1, 0, 0, 1);   // restart mid-run with TICK
        check("restart_no_dec", int'(count_o[0]), 4);
        cycle(1, 7, 0, 1, 0, 1);   // ABORT beats START
        check("abort_start", int'(count_o[0]), 0);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(0, 0, 1, 1, 0, 1);   // TICK at count 1 with ABORT
        idle_cycles(1);

        // Reset mid-run at count 5.
        cycle(1, 5, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 0);
        check("rst_mid_busy", int'(busy_o[0]), 0);
        idle_cycles(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic s, t, ab, ak, r;
            int lv;
            s  = ($urandom_range(0, 99) < 10);
            t  = ($urandom_range(0, 99) < 60);
            ab = ($urandom_range(0, 99) < 4);
            ak = ($urandom_range(0, 99) < 25);
            r  = ($urandom_range(0, 99) >= 2);
            lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
            cycle(s, lv, t, ab, ak, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
